bram_lsu_port: RTL

- Load/store initiator that drives the byte-enabled port A of the dual-port data BRAM (wea/addra/dina in, douta out) from a core-side request/response handshake.
- Converts byte, half and word accesses into byte-lane write enables and replicated write data.
- Extracts and sign/zero-extends read data, accounting for the 1-cycle registered douta latency.
- Rejects misaligned accesses without touching memory. One access in flight at a time.

---
 rtl/bram_lsu_port_if.sv | 47 ++++
 rtl/bram_lsu_port.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_lsu_port_if.sv
// Purpose: bundles the core request/response handshake, the BRAM port-A
// signals and the perf counters of the load/store port into one interface.
// Ports: req_* / rsp_* core handshake, mem_* BRAM port A, perf_* counters.
// Modports: slave = the LSU port itself, master = core plus BRAM side.
`timescale 1ns/1ps
interface bram_lsu_port_if #(
  parameter int ADDR_W = 32
);
  // core request
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  // core response
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  // BRAM port A
  logic [3:0]        mem_wea;
  logic [ADDR_W-1:0] mem_addra;
  logic [31:0]       mem_dina;
  logic [31:0]       mem_douta;
  // counters
  logic [31:0]       perf_loads;
  logic [31:0]       perf_stores;
  logic [31:0]       perf_errs;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  rsp_ready, mem_douta,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_wea, mem_addra, mem_dina,
    output perf_loads, perf_stores, perf_errs
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output rsp_ready, mem_douta,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_wea, mem_addra, mem_dina,
    input  perf_loads, perf_stores, perf_errs
  );
endinterface

// File: rtl/bram_lsu_port.sv
// Purpose: load/store initiator driving byte-enabled BRAM port A from a core
//          request/response handshake; one access in flight, misaligned rejected.
// Latency: rsp_valid in cycle 1 (error), 2 (store), 3 (load) after accept;
//          backpressure: req_ready only in IDLE, response held until rsp_ready.
// Ports: clk, rst_n (sync active-low), bus (bram_lsu_port_if.slave).
// Optional: define LSU_PERF_EN to build saturating perf counters, else tied 0.
`timescale 1ns/1ps
module bram_lsu_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_lsu_port_if.slave      bus
);

  generate
    if (DATA_W != 32) begin : g_bad_data_w
      $fatal(1, "bram_lsu_port: DATA_W must be 32");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // captured request (only the low address bits are needed after accept,
  // the word address lives in r_mem_addra)
  logic [1:0]        r_addr_lo;
  logic [1:0]        r_size;
  logic              r_we;
  logic              r_uns;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [ADDR_W-1:0] r_mem_addra;

  logic              w_req_ready;
  logic              w_rsp_valid;
  logic              w_accept;
  logic              w_req_err;
  logic [3:0]        w_lane_we;
  logic [31:0]       w_wdata_rep;
  logic [3:0]        w_wea;
  logic [31:0]       w_dina;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_ext;

  assign w_accept = bus.req_valid && w_req_ready;

  // size 11 is illegal; half must be 2-byte aligned, word 4-byte aligned
  always_comb begin
    w_req_err = 1'b0;
    case (bus.req_size)
      2'b00:   w_req_err = 1'b0;
      2'b01:   w_req_err = bus.req_addr[0];
      2'b10:   w_req_err = (bus.req_addr[1:0] != 2'b00);
      default: w_req_err = 1'b1;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_req_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS:  w_state_nxt = r_we ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_wea       = 4'b0000;
    w_dina      = 32'h0;
    case (r_state)
      ST_IDLE:   w_req_ready = 1'b1;
      ST_ACCESS: begin
        if (r_we) begin
          w_wea  = w_lane_we;
          w_dina = w_wdata_rep;
        end
      end
      ST_RESP:   w_rsp_valid = 1'b1;
      default:   ;
    endcase
    // reset arriving mid-ACCESS must not let the pending write reach the BRAM
    if (!rst_n) begin
      w_wea  = 4'b0000;
      w_dina = 32'h0;
    end
  end

  // store lane enables and replicated data
  always_comb begin
    w_lane_we   = 4'b1111;
    w_wdata_rep = r_wdata;
    case (r_size)
      2'b00: begin
        w_lane_we   = 4'b0001 << r_addr_lo;
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_lane_we   = r_addr_lo[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      default: begin
        w_lane_we   = 4'b1111;
        w_wdata_rep = r_wdata;
      end
    endcase
  end

  // load lane extraction and sign/zero extension from the registered douta
  always_comb begin
    case (r_addr_lo)
      2'd0:    w_byte = bus.mem_douta[7:0];
      2'd1:    w_byte = bus.mem_douta[15:8];
      2'd2:    w_byte = bus.mem_douta[23:16];
      default: w_byte = bus.mem_douta[31:24];
    endcase
    w_half = r_addr_lo[1] ? bus.mem_douta[31:16] : bus.mem_douta[15:0];
    case (r_size)
      2'b00:   w_load_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_load_ext = bus.mem_douta;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr_lo   <= 2'b00;
      r_size      <= 2'b00;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_wdata     <= 32'h0;
      r_rdata     <= 32'h0;
      r_err       <= 1'b0;
      r_mem_addra <= '0;
    end else begin
      if (w_accept) begin
        r_addr_lo <= bus.req_addr[1:0];
        r_size    <= bus.req_size;
        r_we      <= bus.req_we;
        r_uns     <= bus.req_unsigned;
        r_wdata   <= bus.req_wdata;
        r_err     <= w_req_err;
        r_rdata   <= 32'h0;
        // addra is loaded at accept so it is already valid during ACCESS;
        // errored requests leave it untouched
        if (!w_req_err) begin
          r_mem_addra <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        end
      end
      if (r_state == ST_CAPTURE) begin
        r_rdata <= w_load_ext;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.mem_wea   = w_wea;
  assign bus.mem_dina  = w_dina;
  assign bus.mem_addra = r_mem_addra;

`ifdef LSU_PERF_EN
  logic [31:0] r_perf_loads;
  logic [31:0] r_perf_stores;
  logic [31:0] r_perf_errs;
  logic        w_rsp_hs;

  assign w_rsp_hs = (r_state == ST_RESP) && bus.rsp_ready;

  // counted at the response handshake; errors count only as errors
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_loads  <= 32'h0;
      r_perf_stores <= 32'h0;
      r_perf_errs   <= 32'h0;
    end else if (w_rsp_hs) begin
      if (r_err) begin
        if (r_perf_errs != 32'hFFFF_FFFF) r_perf_errs <= r_perf_errs + 32'd1;
      end else if (r_we) begin
        if (r_perf_stores != 32'hFFFF_FFFF) r_perf_stores <= r_perf_stores + 32'd1;
      end else begin
        if (r_perf_loads != 32'hFFFF_FFFF) r_perf_loads <= r_perf_loads + 32'd1;
      end
    end
  end

  assign bus.perf_loads  = r_perf_loads;
  assign bus.perf_stores = r_perf_stores;
  assign bus.perf_errs   = r_perf_errs;
`else
  assign bus.perf_loads  = 32'h0;
  assign bus.perf_stores = 32'h0;
  assign bus.perf_errs   = 32'h0;
`endif

endmodule
